// File: rtl/conv_window_gen_pkg.sv
// Shared widths, channel layout and FSM encoding for the 3x3 sliding-window generator.
package conv_window_gen_pkg;

  localparam int PICTURE_NUM   = 2;
  localparam int WIDTH_DATA    = 8;
  localparam int WIN_TAPS      = 9;
  localparam int DEF_IMG_W_MAX = 416;
  localparam int DEF_CNT_W     = 9;

  localparam int PIX_W = PICTURE_NUM * WIDTH_DATA;
  localparam int WIN_W = PICTURE_NUM * WIN_TAPS * WIDTH_DATA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // LSB of tap k (k = 3*row + col) of channel p inside the flat window bus.
  function automatic int tap_lsb(input int p, input int k);
    return (p * WIN_TAPS + k) * WIDTH_DATA;
  endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer_ram.sv
// Simple dual-port line RAM: one write port, one read port with a 1-cycle registered read.
module conv_window_gen_line_buffer_ram #(
  parameter int DEPTH  = 416,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [DEPTH];

  // Contents are never reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
    rd_data <= mem_reg[rd_addr];
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line RAMs hold the previous rows, a per-channel
// 3x3 register shifts one column per accepted pixel and is presented one cycle later.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int IMG_W_MAX = DEF_IMG_W_MAX,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  img_width,
  input  logic [CNT_W-1:0]  img_height,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              win_valid,
  output logic [WIN_W-1:0]  win_data,
  output logic              busy,
  output logic              done,
  output logic              err_dim
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] THREE = CNT_W'(3);
  localparam logic [CNT_W-1:0] W_MAX = CNT_W'(IMG_W_MAX);

  state_t state_reg, state_next;

  logic [CNT_W-1:0] width_reg, height_reg;
  logic [CNT_W-1:0] col_reg, col_next;
  logic [CNT_W-1:0] row_reg, row_next;
  logic             win_valid_reg;
  logic             err_dim_reg;

  logic             accept;
  logic             dims_ok;
  logic             start_ok;
  logic             last_col;
  logic             last_row;
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;

  assign accept   = pix_valid && (state_reg == ST_RUN);
  assign dims_ok  = (img_width >= THREE) && (img_width <= W_MAX) && (img_height >= THREE);
  assign start_ok = start && (state_reg == ST_IDLE) && dims_ok;
  assign last_col = (col_reg == width_reg - ONE);
  assign last_row = (row_reg == height_reg - ONE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pix_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (start_ok) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        pix_ready = 1'b1;
        if (accept && last_col && last_row) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- counters
  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (start_ok) begin
      col_next = '0;
      row_next = '0;
    end else if (accept) begin
      if (last_col) begin
        col_next = '0;
        row_next = last_row ? '0 : row_reg + ONE;
      end else begin
        col_next = col_reg + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg       <= '0;
      row_reg       <= '0;
      width_reg     <= '0;
      height_reg    <= '0;
      win_valid_reg <= 1'b0;
      err_dim_reg   <= 1'b0;
    end else begin
      col_reg       <= col_next;
      row_reg       <= row_next;
      win_valid_reg <= accept && (row_reg >= TWO) && (col_reg >= TWO);
      err_dim_reg   <= start && (state_reg == ST_IDLE) && !dims_ok;
      if (start_ok) begin
        width_reg  <= img_width;
        height_reg <= img_height;
      end
    end
  end

  // ---------------------------------------------------------------- line RAMs
  // The read port is addressed with the column of the *next* pixel, so the RAM's
  // registered output already holds lb[col_reg] when that pixel arrives; this hides
  // the read latency and keeps pixel-to-window latency at one cycle.
  conv_window_gen_line_buffer_ram #(
    .DEPTH  (IMG_W_MAX),
    .DATA_W (PIX_W),
    .ADDR_W (CNT_W)
  ) u_lb0 (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (col_reg),
    .wr_data (pix_data),
    .rd_addr (col_next),
    .rd_data (lb0_rd)
  );

  conv_window_gen_line_buffer_ram #(
    .DEPTH  (IMG_W_MAX),
    .DATA_W (PIX_W),
    .ADDR_W (CNT_W)
  ) u_lb1 (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (col_reg),
    .wr_data (lb0_rd),
    .rd_addr (col_next),
    .rd_data (lb1_rd)
  );

  // ---------------------------------------------------------------- window registers
  genvar gi, gj;
  generate
    for (gi = 0; gi < PICTURE_NUM; gi++) begin : g_ch
      logic [WIDTH_DATA-1:0] taps_reg [WIN_TAPS];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < WIN_TAPS; k++) begin
            taps_reg[k] <= '0;
          end
        end else if (accept) begin
          for (int i = 0; i < 3; i++) begin
            taps_reg[3*i]   <= taps_reg[3*i+1];
            taps_reg[3*i+1] <= taps_reg[3*i+2];
          end
          // New right column, oldest row on top.
          taps_reg[2] <= lb1_rd[gi*WIDTH_DATA +: WIDTH_DATA];
          taps_reg[5] <= lb0_rd[gi*WIDTH_DATA +: WIDTH_DATA];
          taps_reg[8] <= pix_data[gi*WIDTH_DATA +: WIDTH_DATA];
        end
      end

      for (gj = 0; gj < WIN_TAPS; gj++) begin : g_tap
        localparam int LSB = tap_lsb(gi, gj);
        assign win_data[LSB +: WIDTH_DATA] = taps_reg[gj];
      end
    end
  endgenerate

  assign win_valid = win_valid_reg;
  assign err_dim   = err_dim_reg;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: frames with hand-derived window contents.
module tb_conv_window_gen;
  import conv_window_gen_pkg::*;

  localparam int CW = DEF_CNT_W;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CW-1:0]    img_width;
  logic [CW-1:0]    img_height;
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic             win_valid;
  logic [WIN_W-1:0] win_data;
  logic             busy;
  logic             done;
  logic             err_dim;

  int checks   = 0;
  int failures = 0;
  int win_cnt;
  logic [WIN_W-1:0] first_win, last_win;

  conv_window_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .img_width  (img_width),
    .img_height (img_height),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .win_valid  (win_valid),
    .win_data   (win_data),
    .busy       (busy),
    .done       (done),
    .err_dim    (err_dim)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Test image: channel 0 = base + r*16 + c, channel 1 = base + 3r + 5c + 1 (mod 256).
  function automatic logic [WIDTH_DATA-1:0] pix_val(input int p, input int r, input int c,
                                                    input int base);
    if (p == 0) return WIDTH_DATA'(base + r * 16 + c);
    return WIDTH_DATA'(base + r * 3 + c * 5 + 1);
  endfunction

  function automatic logic [PIX_W-1:0] pix_vec(input int r, input int c, input int base);
    logic [PIX_W-1:0] v;
    v = '0;
    for (int p = 0; p < PICTURE_NUM; p++) v[p*WIDTH_DATA +: WIDTH_DATA] = pix_val(p, r, c, base);
    return v;
  endfunction

  // Window whose bottom-right pixel is (r,c).
  function automatic logic [WIN_W-1:0] exp_win(input int r, input int c, input int base);
    logic [WIN_W-1:0] v;
    v = '0;
    for (int p = 0; p < PICTURE_NUM; p++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          v[(p*WIN_TAPS + 3*i + j)*WIDTH_DATA +: WIDTH_DATA] = pix_val(p, r-2+i, c-2+j, base);
    return v;
  endfunction

  task automatic run_frame(input int w, input int h, input int base, input bit gaps,
                           input int abort_at, input bit run_start, input bit flush_start);
    logic [WIN_W-1:0] exp_w;
    logic             exp_v;
    logic             last;
    logic             prev_win;
    int               n;
    n = 0;
    win_cnt = 0;
    prev_win = 1'b0;
    exp_w = '0;
    start = 1'b1; img_width = CW'(w); img_height = CW'(h);
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || pix_ready !== 1'b1) begin
      failures++;
      $display("FAIL frame_start busy=%b pix_ready=%b required 1/1", busy, pix_ready);
    end
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (abort_at >= 0 && n == abort_at) return;
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            pix_valid = 1'b0;
            pix_data  = PIX_W'($urandom);
            @(posedge clk); #1;
            checks++;
            if (win_valid !== 1'b0) begin
              failures++;
              $display("FAIL gap_win_valid r=%0d c=%0d got=%b required=0", r, c, win_valid);
            end
            if (prev_win) begin
              checks++;
              if (win_data !== exp_w) begin
                failures++;
                $display("FAIL gap_hold r=%0d c=%0d got=%h required=%h", r, c, win_data, exp_w);
              end
            end
          end
        end
        pix_valid = 1'b1;
        pix_data  = pix_vec(r, c, base);
        if (run_start && n == w) begin
          start = 1'b1; img_width = CW'(3); img_height = CW'(3);
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        start     = 1'b0;
        n++;
        exp_v = (r >= 2) && (c >= 2);
        last  = (r == h-1) && (c == w-1);
        checks++;
        if (win_valid !== exp_v) begin
          failures++;
          $display("FAIL win_valid r=%0d c=%0d got=%b required=%b", r, c, win_valid, exp_v);
        end
        if (win_valid === 1'b1) begin
          if (win_cnt == 0) first_win = win_data;
          last_win = win_data;
          win_cnt++;
        end
        if (exp_v) begin
          exp_w = exp_win(r, c, base);
          checks++;
          if (win_data !== exp_w) begin
            failures++;
            $display("FAIL win_data r=%0d c=%0d got=%h required=%h", r, c, win_data, exp_w);
          end
        end
        prev_win = exp_v;
        checks++;
        if (done !== last) begin
          failures++;
          $display("FAIL done r=%0d c=%0d got=%b required=%b", r, c, done, last);
        end
      end
    end
    if (flush_start) begin
      start = 1'b1; img_width = CW'(4); img_height = CW'(3);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || win_valid !== 1'b0 || err_dim !== 1'b0) begin
      failures++;
      $display("FAIL frame_end busy=%b done=%b win_valid=%b err_dim=%b required all 0",
               busy, done, win_valid, err_dim);
    end
    checks++;
    if (win_cnt != (w-2)*(h-2)) begin
      failures++;
      $display("FAIL window_count got=%0d required=%0d", win_cnt, (w-2)*(h-2));
    end
    $display("frame W=%0d H=%0d base=%0d windows=%0d", w, h, base, win_cnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    img_width = '0; img_height = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || pix_ready !== 1'b0 || win_valid !== 1'b0 || done !== 1'b0 ||
        err_dim !== 1'b0 || win_data !== '0) begin
      failures++;
      $display("FAIL reset_state busy=%b ready=%b wv=%b done=%b err=%b win=%h required zeros",
               busy, pix_ready, win_valid, done, err_dim, win_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || pix_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b pix_ready=%b required 0/0", busy, pix_ready);
    end
    $display("reset done");
  endtask

  task automatic test_basic();
    int exp_first [9] = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
    int exp_last  [9] = '{18, 19, 20, 34, 35, 36, 50, 51, 52};
    run_frame(5, 4, 0, 1'b0, -1, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (first_win[k*WIDTH_DATA +: WIDTH_DATA] !== WIDTH_DATA'(exp_first[k])) begin
        failures++;
        $display("FAIL first_tap%0d got=%0d required=%0d", k,
                 first_win[k*WIDTH_DATA +: WIDTH_DATA], exp_first[k]);
      end
      checks++;
      if (last_win[k*WIDTH_DATA +: WIDTH_DATA] !== WIDTH_DATA'(exp_last[k])) begin
        failures++;
        $display("FAIL last_tap%0d got=%0d required=%0d", k,
                 last_win[k*WIDTH_DATA +: WIDTH_DATA], exp_last[k]);
      end
    end
  endtask

  task automatic test_gaps();
    run_frame(5, 4, 0, 1'b1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_illegal_dims();
    int bad_w [3] = '{2, 5, DEF_IMG_W_MAX + 1};
    int bad_h [3] = '{4, 2, 3};
    for (int t = 0; t < 3; t++) begin
      start = 1'b1; img_width = CW'(bad_w[t]); img_height = CW'(bad_h[t]);
      pix_valid = 1'b1; pix_data = pix_vec(7, 7, 0);
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (err_dim !== 1'b1 || busy !== 1'b0 || pix_ready !== 1'b0 || win_valid !== 1'b0) begin
        failures++;
        $display("FAIL illegal_dims W=%0d H=%0d err=%b busy=%b ready=%b wv=%b required 1/0/0/0",
                 bad_w[t], bad_h[t], err_dim, busy, pix_ready, win_valid);
      end
      @(posedge clk); #1;
      pix_valid = 1'b0;
      checks++;
      if (err_dim !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || win_valid !== 1'b0) begin
        failures++;
        $display("FAIL illegal_dims_after W=%0d H=%0d err=%b busy=%b done=%b wv=%b required 0",
                 bad_w[t], bad_h[t], err_dim, busy, done, win_valid);
      end
      $display("illegal start W=%0d H=%0d rejected", bad_w[t], bad_h[t]);
    end
  endtask

  task automatic test_max_width();
    run_frame(DEF_IMG_W_MAX, 3, 3, 1'b0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    run_frame(6, 5, 50, 1'b0, 2*6 + 3, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || pix_ready !== 1'b0 || win_valid !== 1'b0 || done !== 1'b0 ||
        win_data !== '0) begin
      failures++;
      $display("FAIL mid_frame_reset busy=%b ready=%b wv=%b done=%b win=%h required zeros",
               busy, pix_ready, win_valid, done, win_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(4, 3, 100, 1'b0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame(5, 3, 10, 1'b0, -1, 1'b1, 1'b1);
    run_frame(4, 4, 20, 1'b0, -1, 1'b0, 1'b0);
    run_frame(3, 3, 30, 1'b1, -1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_illegal_dims();
    test_max_width();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
